// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ requesters.
// Results and flags are held in a single-entry response register tagged with the owner ID.

module alu #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             carry
);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] diff_s;

    // Opcode decode; carry and overflow only carry meaning for ADD/SUB, carry on SUB is borrow.
    always_comb begin
        sum_s    = {1'b0, a} + {1'b0, b};
        diff_s   = {1'b0, a} - {1'b0, b};
        result   = {WIDTH{1'b0}};
        overflow = 1'b0;
        carry    = 1'b0;
        case (op)
            3'b000: begin
                result   = sum_s[WIDTH-1:0];
                carry    = sum_s[WIDTH];
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            3'b001: begin
                result   = diff_s[WIDTH-1:0];
                carry    = diff_s[WIDTH];
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            3'b010:  result = a & b;
            3'b011:  result = a | b;
            3'b100:  result = a ^ b;
            3'b101:  result = ~a;
            3'b110:  result = a << b[2:0];
            3'b111:  result = a >> b[2:0];
            default: result = {WIDTH{1'b0}};
        endcase
        zero = (result == {WIDTH{1'b0}});
    end

endmodule

module alu_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    input  logic [NUM_REQ*3-1:0]       req_op,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]           rsp_result,
    output logic                       rsp_zero,
    output logic                       rsp_overflow,
    output logic                       rsp_carry,
    output logic [15:0]                op_count
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ID_W-1:0]   prio_ptr_r;
    logic [ID_W-1:0]   cand_s;
    logic [ID_W-1:0]   grant_idx_s;
    logic              grant_found_s;
    logic              issue_open_s;
    logic              grant_valid_s;
    logic              rsp_done_s;
    logic [WIDTH-1:0]  alu_a_s;
    logic [WIDTH-1:0]  alu_b_s;
    logic [2:0]        alu_op_s;
    logic [WIDTH-1:0]  alu_result_s;
    logic              alu_zero_s;
    logic              alu_overflow_s;
    logic              alu_carry_s;
    logic [ID_W-1:0]   rsp_id_r;
    logic [WIDTH-1:0]  rsp_result_r;
    logic              rsp_zero_r;
    logic              rsp_overflow_r;
    logic              rsp_carry_r;
    logic [15:0]       op_count_r;

    // Round-robin search: scanning from the far end lets the candidate nearest prio_ptr win.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = {ID_W{1'b0}};
        cand_s        = {ID_W{1'b0}};
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand_s        = ID_W'((int'(prio_ptr_r) + k) % NUM_REQ);
            grant_idx_s   = req_valid[cand_s] ? cand_s : grant_idx_s;
            grant_found_s = grant_found_s | req_valid[cand_s];
        end
    end

    // Issue slot, grant vector and operand mux (requester 0 when idle).
    always_comb begin
        issue_open_s  = (state_r == EMPTY) || rsp_ready;
        grant_valid_s = issue_open_s && grant_found_s;
        rsp_done_s    = (state_r == FULL) && rsp_ready;
        if (grant_valid_s) begin
            req_ready = NUM_REQ'(1) << grant_idx_s;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
        alu_a_s  = req_a[int'(grant_idx_s)*WIDTH +: WIDTH];
        alu_b_s  = req_b[int'(grant_idx_s)*WIDTH +: WIDTH];
        alu_op_s = req_op[int'(grant_idx_s)*3 +: 3];
    end

    alu #(.WIDTH(WIDTH)) u_alu (
        .a        (alu_a_s),
        .b        (alu_b_s),
        .op       (alu_op_s),
        .result   (alu_result_s),
        .zero     (alu_zero_s),
        .overflow (alu_overflow_s),
        .carry    (alu_carry_s)
    );

    // Next-state logic: a grant always fills the slot, a bare retire empties it.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            EMPTY: begin
                if (grant_valid_s) state_nxt_s = FULL;
                else               state_nxt_s = EMPTY;
            end
            FULL: begin
                if (grant_valid_s)   state_nxt_s = FULL;
                else if (rsp_ready)  state_nxt_s = EMPTY;
                else                 state_nxt_s = FULL;
            end
            default: state_nxt_s = EMPTY;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= EMPTY;
        else     state_r <= state_nxt_s;
    end

    // Response capture and priority pointer advance on every grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_id_r       <= {ID_W{1'b0}};
            rsp_result_r   <= {WIDTH{1'b0}};
            rsp_zero_r     <= 1'b0;
            rsp_overflow_r <= 1'b0;
            rsp_carry_r    <= 1'b0;
            prio_ptr_r     <= {ID_W{1'b0}};
        end else if (grant_valid_s) begin
            rsp_id_r       <= grant_idx_s;
            rsp_result_r   <= alu_result_s;
            rsp_zero_r     <= alu_zero_s;
            rsp_overflow_r <= alu_overflow_s;
            rsp_carry_r    <= alu_carry_s;
            if (grant_idx_s == ID_W'(NUM_REQ - 1)) prio_ptr_r <= {ID_W{1'b0}};
            else                                   prio_ptr_r <= grant_idx_s + ID_W'(1);
        end else begin
            rsp_id_r       <= rsp_id_r;
            rsp_result_r   <= rsp_result_r;
            rsp_zero_r     <= rsp_zero_r;
            rsp_overflow_r <= rsp_overflow_r;
            rsp_carry_r    <= rsp_carry_r;
            prio_ptr_r     <= prio_ptr_r;
        end
    end

    // Completed-handshake counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             op_count_r <= 16'd0;
        else if (rsp_done_s) op_count_r <= op_count_r + 16'd1;
        else                 op_count_r <= op_count_r;
    end

    assign rsp_valid    = (state_r == FULL);
    assign rsp_id       = rsp_id_r;
    assign rsp_result   = rsp_result_r;
    assign rsp_zero     = rsp_zero_r;
    assign rsp_overflow = rsp_overflow_r;
    assign rsp_carry    = rsp_carry_r;
    assign op_count     = op_count_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: handshakes, flags, fairness, backpressure, reset and counter wrap.

module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [11:0] req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_result;
    logic        rsp_zero;
    logic        rsp_overflow;
    logic        rsp_carry;
    logic [15:0] op_count;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] r;
        logic       z;
        logic       o;
        logic       c;
    } vec_t;

    vec_t vecs [10];

    alu_arbiter #(.WIDTH(8), .NUM_REQ(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_op       (req_op),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_zero     (rsp_zero),
        .rsp_overflow (rsp_overflow),
        .rsp_carry    (rsp_carry),
        .op_count     (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
        req_op[i*3 +: 3] = op;
    endtask

    task automatic chk_rsp(input string tag, input logic [1:0] id, input logic [7:0] r,
                           input logic z, input logic o, input logic c);
        chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, "_id"}, {30'd0, rsp_id}, {30'd0, id});
        chk({tag, "_result"}, {24'd0, rsp_result}, {24'd0, r});
        chk({tag, "_zero"}, {31'd0, rsp_zero}, {31'd0, z});
        chk({tag, "_ovf"}, {31'd0, rsp_overflow}, {31'd0, o});
        chk({tag, "_carry"}, {31'd0, rsp_carry}, {31'd0, c});
    endtask

    initial begin
        vecs[0] = '{8'h00, 8'h01, 3'b001, 8'hFF, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{8'h05, 8'h05, 3'b001, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'hFF, 8'h01, 3'b000, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{8'h80, 8'h01, 3'b001, 8'h7F, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'hB4, 8'h3A, 3'b010, 8'h30, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{8'hB4, 8'h3A, 3'b011, 8'hBE, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{8'hB4, 8'h3A, 3'b100, 8'h8E, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{8'hB4, 8'h3A, 3'b101, 8'h4B, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{8'hB4, 8'h3A, 3'b110, 8'hD0, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{8'hB4, 8'h3A, 3'b111, 8'h2D, 1'b0, 1'b0, 1'b0};

        rst       = 1'b1;
        req_valid = 4'b0000;
        req_a     = 32'd0;
        req_b     = 32'd0;
        req_op    = 12'd0;
        rsp_ready = 1'b0;
        step();
        step();
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_id", {30'd0, rsp_id}, 32'd0);
        chk("reset_rsp_result", {24'd0, rsp_result}, 32'd0);
        chk("reset_flags", {29'd0, rsp_zero, rsp_overflow, rsp_carry}, 32'd0);
        chk("reset_op_count", {16'd0, op_count}, 32'd0);
        chk("reset_req_ready", {28'd0, req_ready}, 32'd0);
        rst = 1'b0;

        // Single ADD from requester 1
        set_req(1, 8'h7F, 8'h01, 3'b000);
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        #1;
        chk("add_req_ready", {28'd0, req_ready}, 32'h2);
        step();
        req_valid = 4'b0000;
        chk_rsp("add", 2'd1, 8'h80, 1'b0, 1'b1, 1'b0);
        chk("add_count_before", {16'd0, op_count}, 32'd0);
        #1;
        chk("idle_req_ready", {28'd0, req_ready}, 32'd0);
        step();
        chk("add_count_after", {16'd0, op_count}, 32'd1);
        chk("add_empty", {31'd0, rsp_valid}, 32'd0);

        // Back-to-back vectors from requester 0 exercising every opcode and flag
        req_valid = 4'b0001;
        for (int v = 0; v < 10; v++) begin
            set_req(0, vecs[v].a, vecs[v].b, vecs[v].op);
            step();
            chk_rsp($sformatf("vec%0d", v), 2'd0, vecs[v].r, vecs[v].z, vecs[v].o, vecs[v].c);
        end
        req_valid = 4'b0000;
        chk("vec_count_mid", {16'd0, op_count}, 32'd10);
        step();
        chk("vec_count_end", {16'd0, op_count}, 32'd11);

        // Fairness from reset with all requesters valid
        rst = 1'b1;
        #2;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 8'(i * 16), 8'h01, 3'b000);
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("fair_ready%0d", k), {28'd0, req_ready}, 32'(1 << (k % 4)));
            step();
            chk($sformatf("fair_id%0d", k), {30'd0, rsp_id}, 32'(k % 4));
            chk($sformatf("fair_res%0d", k), {24'd0, rsp_result}, 32'((k % 4) * 16 + 1));
        end
        chk("fair_count", {16'd0, op_count}, 32'd5);

        // Pointer skip: prio_ptr is 2, only 0 and 3 valid
        req_valid = 4'b1001;
        #1;
        chk("skip_ready3", {28'd0, req_ready}, 32'h8);
        step();
        chk("skip_id3", {30'd0, rsp_id}, 32'd3);
        chk("skip_ready0", {28'd0, req_ready}, 32'h1);
        step();
        chk("skip_id0", {30'd0, rsp_id}, 32'd0);

        // Backpressure: held response must stay frozen
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("bp_ready%0d", k), {28'd0, req_ready}, 32'd0);
            step();
            chk_rsp($sformatf("bp%0d", k), 2'd0, 8'h01, 1'b0, 1'b0, 1'b0);
            chk($sformatf("bp_count%0d", k), {16'd0, op_count}, 32'd7);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", {28'd0, req_ready}, 32'h2);
        step();
        chk_rsp("bp_release", 2'd1, 8'h11, 1'b0, 1'b0, 1'b0);
        chk("bp_release_count", {16'd0, op_count}, 32'd8);

        // Reset while holding a response owned by requester 2
        step();
        chk("pre_rst_id", {30'd0, rsp_id}, 32'd2);
        rsp_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_op_count", {16'd0, op_count}, 32'd0);
        chk("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
        step();
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1;
        chk("post_rst_ready", {28'd0, req_ready}, 32'h1);
        step();
        chk("post_rst_id", {30'd0, rsp_id}, 32'd0);
        chk("post_rst_count", {16'd0, op_count}, 32'd0);

        // Counter wrap: one handshake per cycle
        for (int k = 0; k < 65535; k++) step();
        chk("wrap_ffff", {16'd0, op_count}, 32'hFFFF);
        step();
        chk("wrap_zero", {16'd0, op_count}, 32'd0);
        chk("wrap_valid", {31'd0, rsp_valid}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one `alu` instance between `NUM_REQ` independent requesters using round-robin arbitration with valid/ready handshakes on every side. At most one operation is issued per clock. The ALU output and flags are captured in a single-entry response register tagged with the requester ID. The block sits between the per-requester operand sources and the shared 8-bit ALU datapath.

## Interface
- `WIDTH`, 8: operand/result width; passed through to the internal `alu`.
- `NUM_REQ`, 4: number of requesters; legal range 2..8. Local `ID_W = $clog2(NUM_REQ)`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  bit i: requester i presents an operation.
- `req_ready`  out  NUM_REQ  bit i: requester i's operation is accepted this cycle; one-hot or zero.
- `req_a`  in  NUM_REQ*WIDTH  operand A; slice i = bits [i*WIDTH +: WIDTH].
- `req_b`  in  NUM_REQ*WIDTH  operand B, sliced as `req_a`.
- `req_op`  in  NUM_REQ*3  opcode, slice i = [i*3 +: 3]. Encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 SHL, 111 SHR.
- `rsp_valid`  out  1  response register holds a result.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  ID_W  index of the requester that owns the response.
- `rsp_result`  out  WIDTH  registered ALU result.
- `rsp_zero`, `rsp_overflow`, `rsp_carry`  out  1 each  registered ALU flags.
- `op_count`  out  16  count of completed response handshakes; wraps from 0xFFFF to 0.

## Operation
- Two-state FSM:
  - EMPTY: `rsp_valid` = 0.
  - FULL: `rsp_valid` = 1.
- Issue slot is open when the FSM is EMPTY, or when it is FULL and `rsp_ready` = 1 (pass-through).
- Grant rule:
  - When the issue slot is open, grant the first i with `req_valid[i]` = 1, searching from `prio_ptr` upward modulo NUM_REQ.
  - `req_ready[grant]` = 1. All other bits are 0.
  - When the issue slot is closed, or no request is valid, `req_ready` = 0.
- ALU input mux: the granted requester's a/b/op slices drive the internal `alu`. With no grant, the mux selects requester 0 and the output is ignored.
- On a grant edge:
  - Capture result, flags and the grant index into the response registers.
  - Set `prio_ptr` = (grant + 1) mod NUM_REQ.
  - FSM goes to, or stays in, FULL.
- With no grant, `prio_ptr` is unchanged.
- Response handshake:
  - `rsp_valid` & `rsp_ready` completes a response and increments `op_count`.
  - If there is no new grant in that cycle, the FSM goes to EMPTY.
- Flags:
  - Overflow and carry are meaningful only for ADD/SUB; they are 0 for all other ops.
  - SUB carry = borrow: 1 when a < b unsigned.
  - Shifts use b[2:0].
- `req_ready` is combinational from `req_valid`, `rsp_ready`, FSM state and `prio_ptr`.
- Requesters must hold a/b/op stable while valid and not ready. They must not drop valid before ready; the arbiter does not check this.

## Timing
- Reset values:
  - FSM = EMPTY, `rsp_valid` = 0, `rsp_id` = 0, `rsp_result` = 0, all flags 0.
  - `prio_ptr` = 0, `op_count` = 0, `req_ready` = 0 (follows from EMPTY with no valid).
- Latency: a request accepted on edge N appears with `rsp_valid` = 1 after edge N, i.e. one cycle.
- Throughput: one operation per cycle while `rsp_ready` is held at 1.
- Backpressure: while FULL and `rsp_ready` = 0, all `rsp_*` outputs stay stable, `req_ready` = 0, and `prio_ptr` is frozen.
- Simultaneous complete and grant: in the same cycle the response retires, `op_count` increments, and the new result loads. The FSM stays FULL.
- Reset mid-operation: a held response is discarded with no handshake, and all state returns to the reset values immediately (asynchronous).
- `op_count` wraps 0xFFFF to 0x0000 on the next completed handshake.

## Test plan
- Single ADD: req1 valid, a=0x7F, b=0x01, op=000, `rsp_ready`=1.
  - `req_ready`=0010 in the same cycle.
  - Next cycle: `rsp_valid`=1, id=1, result=0x80, overflow=1, carry=0, zero=0.
  - `op_count` becomes 1 after that response completes.
- SUB borrow: req0 a=0x00, b=0x01, op=001 -> result=0xFF, carry=1, overflow=0. Then a=0x05, b=0x05 -> result=0x00, zero=1, carry=0.
- Fairness: all four requesters valid continuously, `rsp_ready`=1, from reset.
  - Grants go 0,1,2,3,0,1, one per cycle.
  - `rsp_id` follows the same sequence one cycle later.
- Pointer skip: after a grant to req1 (`prio_ptr`=2), only req0 and req3 valid -> grant 3, then 0.
- Backpressure: `rsp_ready`=0 for 5 cycles with FULL and all requesters valid.
  - `req_ready`=0 and `rsp_*` unchanged for all 5 cycles.
  - Raising `rsp_ready` retires the held response and grants the next requester in the same cycle.
- Reset mid-op: assert `rst` while FULL with id=2.
  - `rsp_valid`=0 immediately; `op_count` and `prio_ptr` read 0.
  - First post-reset grant with all requesters valid goes to req0.
